// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, scheduler response encoding, handshake codes
// and the IN scheduler state encoding.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] TX_DATA0 = 2'd0;
    localparam logic [1:0] TX_DATA1 = 2'd1;
    localparam logic [1:0] TX_NAK   = 2'd2;
    localparam logic [1:0] TX_STALL = 2'd3;

    typedef enum logic [1:0] {
        HS_NONE    = 2'd0,
        HS_ACK     = 2'd1,
        HS_TIMEOUT = 2'd2
    } hs_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_FILL    = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_HS = 3'd4;

    function automatic logic [3:0] tx_to_pid(input logic [1:0] tx);
        logic [3:0] pid;
        case (tx)
            TX_DATA0: pid = PID_DATA0;
            TX_DATA1: pid = PID_DATA1;
            TX_NAK:   pid = PID_NAK;
            default:  pid = PID_STALL;
        endcase
        return pid;
    endfunction

endpackage

// File: rtl/usb_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle register.
// Same-cycle priority: clear-all over SETUP (forces EP0 to 1) over ACK flip.
module usb_toggle_bank #(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned EW     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              setup,
    input  logic              flip,
    input  logic [EW-1:0]     flip_ep,
    output logic [NUM_EP-1:0] toggle
);

    logic [NUM_EP-1:0] toggle_q;
    logic [NUM_EP-1:0] toggle_d;

    always_comb begin
        toggle_d = toggle_q;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            if (clr) begin
                toggle_d[i] = 1'b0;
            end else if (setup && (i == 0)) begin
                toggle_d[i] = 1'b1;
            end else if (flip && (flip_ep == EW'(i))) begin
                toggle_d[i] = ~toggle_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle = toggle_q;

endmodule

// File: rtl/usb_in_scheduler.sv
// Answers IN tokens with DATA0/DATA1, NAK or STALL; copies the endpoint packet
// into the shared send queue and tracks per-endpoint data toggles.
module usb_in_scheduler
    import usb_pkg::*;
#(
    parameter int unsigned NUM_EP  = 4,
    parameter int unsigned MAX_PKT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_token,
    input  logic [3:0]          token_ep,
    input  logic                setup_rx,
    input  logic                toggle_clr,
    input  logic [NUM_EP-1:0]   ep_ready,
    input  logic [NUM_EP-1:0]   ep_stall,
    input  logic [7*NUM_EP-1:0] ep_len,
    input  logic [8*NUM_EP-1:0] ep_data,
    output logic [NUM_EP-1:0]   ep_rd_en,
    output logic [NUM_EP-1:0]   ep_done,
    output logic [NUM_EP-1:0]   ep_rewind,
    output logic                send_w_en,
    output logic [7:0]          send_data,
    input  logic                send_empty,
    output logic                tx_start,
    output logic [1:0]          tx_pid,
    input  logic                host_ack,
    input  logic                host_timeout,
    output logic                busy
);

    localparam int unsigned CW = $clog2(MAX_PKT + 1);
    localparam int unsigned EW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    logic [2:0]        state_q,     state_d;
    logic [3:0]        ep_q,        ep_d;
    logic [CW-1:0]     len_q,       len_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic              is_data_q,   is_data_d;
    logic [1:0]        pid_q,       pid_d;
    logic              send_w_en_q, send_w_en_d;
    logic [NUM_EP-1:0] done_q,      done_d;
    logic [NUM_EP-1:0] rewind_q,    rewind_d;

    logic [6:0]        len_arr  [NUM_EP];
    logic [7:0]        data_arr [NUM_EP];
    logic [EW-1:0]     ep_idx;
    logic              ep_in_range;
    logic [CW-1:0]     len_clamped;
    logic              rd_fill;
    logic              ack_flip;
    logic [NUM_EP-1:0] toggle;
    hs_e               hs;

    for (genvar g = 0; g < NUM_EP; g++) begin : g_unpack
        assign len_arr[g]  = ep_len[7*g +: 7];
        assign data_arr[g] = ep_data[8*g +: 8];
    end

    assign ep_idx      = ep_q[EW-1:0];
    assign ep_in_range = (32'(ep_q) < NUM_EP);
    assign len_clamped = (32'(len_arr[ep_idx]) > MAX_PKT) ? CW'(MAX_PKT) : CW'(len_arr[ep_idx]);

    // FILL runs one cycle past the last read so the final queue write lands before SEND.
    assign rd_fill  = (state_q == ST_FILL) && (cnt_q != len_q);
    assign ack_flip = (state_q == ST_WAIT_HS) && (hs == HS_ACK);

    always_comb begin
        if (host_ack) begin
            hs = HS_ACK;
        end else if (host_timeout) begin
            hs = HS_TIMEOUT;
        end else begin
            hs = HS_NONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        ep_d        = ep_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        is_data_d   = is_data_q;
        pid_d       = pid_q;
        send_w_en_d = rd_fill;
        done_d      = '0;
        rewind_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_token) begin
                    ep_d    = token_ep;
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!ep_in_range || ep_stall[ep_idx]) begin
                    pid_d     = TX_STALL;
                    is_data_d = 1'b0;
                    state_d   = ST_SEND;
                end else if (!ep_ready[ep_idx] || !send_empty) begin
                    pid_d     = TX_NAK;
                    is_data_d = 1'b0;
                    state_d   = ST_SEND;
                end else begin
                    is_data_d = 1'b1;
                    len_d     = len_clamped;
                    cnt_d     = '0;
                    state_d   = (len_clamped == '0) ? ST_SEND : ST_FILL;
                end
            end
            ST_FILL: begin
                if (cnt_q == len_q) begin
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SEND: begin
                state_d = is_data_q ? ST_WAIT_HS : ST_IDLE;
            end
            ST_WAIT_HS: begin
                for (int unsigned i = 0; i < NUM_EP; i++) begin
                    if (ep_idx == EW'(i)) begin
                        done_d[i]   = (hs == HS_ACK);
                        rewind_d[i] = (hs == HS_TIMEOUT);
                    end
                end
                if (hs != HS_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ep_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            is_data_q   <= 1'b0;
            pid_q       <= '0;
            send_w_en_q <= 1'b0;
            done_q      <= '0;
            rewind_q    <= '0;
        end else begin
            state_q     <= state_d;
            ep_q        <= ep_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            is_data_q   <= is_data_d;
            pid_q       <= pid_d;
            send_w_en_q <= send_w_en_d;
            done_q      <= done_d;
            rewind_q    <= rewind_d;
        end
    end

    usb_toggle_bank #(
        .NUM_EP (NUM_EP),
        .EW     (EW)
    ) u_toggle_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (toggle_clr),
        .setup   (setup_rx),
        .flip    (ack_flip),
        .flip_ep (ep_idx),
        .toggle  (toggle)
    );

    always_comb begin
        ep_rd_en = '0;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            ep_rd_en[i] = rd_fill && (ep_idx == EW'(i));
        end
    end

    // Data PID is taken from the toggle at SEND time, so late SETUP/clear still counts.
    always_comb begin
        tx_pid = '0;
        if (state_q == ST_SEND) begin
            tx_pid = is_data_q ? {1'b0, toggle[ep_idx]} : pid_q;
        end
    end

    assign ep_done   = done_q;
    assign ep_rewind = rewind_q;
    assign send_w_en = send_w_en_q;
    assign send_data = send_w_en_q ? data_arr[ep_idx] : '0;
    assign tx_start  = (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/usb_in_scheduler.md
# usb_in_scheduler

Sequences IN transactions for all device endpoints onto the single shared USB send queue. On each IN token it chooses the response: DATA0/DATA1 payload, NAK or STALL. For a data response it copies the endpoint's packet into the send queue and tracks the data toggle per endpoint. It sits between the token/handshake decoder, the endpoint buffers (EP0 control logic included) and the send queue feeding the serializer.

## Interface
Parameters:
- NUM_EP, 4, number of endpoints (EP0 included), 1..16
- MAX_PKT, 64, maximum payload bytes per packet

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_token  in  1  one-cycle pulse: IN token addressed to this device
- token_ep  in  4  endpoint number, valid with in_token
- setup_rx  in  1  pulse: SETUP received on EP0
- toggle_clr  in  1  pulse: clear all toggles (SET_CONFIGURATION)
- ep_ready  in  NUM_EP  endpoint holds a complete packet
- ep_stall  in  NUM_EP  endpoint halted
- ep_len  in  7*NUM_EP  packet length per endpoint, 0..MAX_PKT
- ep_data  in  8*NUM_EP  read data per endpoint; valid the cycle after ep_rd_en
- ep_rd_en  out  NUM_EP  byte read strobe, at most one bit set
- ep_done  out  NUM_EP  pulse: packet ACKed, endpoint discards it
- ep_rewind  out  NUM_EP  pulse: packet not ACKed, endpoint rewinds its read pointer
- send_w_en  out  1  send queue write enable
- send_data  out  8  send queue write data
- send_empty  in  1  send queue empty
- tx_start  out  1  pulse: serializer begins response
- tx_pid  out  2  0=DATA0, 1=DATA1, 2=NAK, 3=STALL; valid with tx_start
- host_ack  in  1  pulse: ACK received after data
- host_timeout  in  1  pulse: no handshake within bus turnaround
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CHECK, FILL, SEND, WAIT_HS.
- IDLE: on in_token, latch token_ep, go to CHECK. in_token outside IDLE is ignored.
- CHECK, evaluated in priority order:
  - token_ep >= NUM_EP or ep_stall set: tx_pid=STALL, go to SEND.
  - ep_ready clear, or send_empty clear: NAK, go to SEND.
  - Otherwise latch the length L. If L==0, go to SEND (zero-length packet). Else go to FILL.
- FILL: byte counter from 0 to L-1. ep_rd_en[ep] is asserted for L consecutive cycles. send_w_en and send_data follow one cycle later, for L cycles. Then go to SEND.
- SEND: one-cycle tx_start pulse. For data responses, tx_pid = toggle[ep]. NAK/STALL return to IDLE; data goes to WAIT_HS.
- WAIT_HS:
  - host_ack: toggle[ep] flips, ep_done[ep] pulses, go to IDLE.
  - host_timeout: toggle unchanged, ep_rewind[ep] pulses, go to IDLE.
  - ack and timeout in the same cycle: ack wins.
- Toggle bank, NUM_EP bits:
  - setup_rx sets toggle[0]=1.
  - toggle_clr zeroes all bits.
  - Same-cycle priority: toggle_clr > setup_rx > ack flip.
- host_ack/host_timeout outside WAIT_HS are ignored.
- ep_len values above MAX_PKT are clamped to MAX_PKT.

## Timing
- Reset values: all outputs 0, all toggles 0, state IDLE.
- A reset mid-FILL or mid-WAIT_HS aborts without ep_done or ep_rewind. Partial send queue contents are the serializer's responsibility.
- in_token at cycle t: CHECK at t+1.
  - NAK/STALL: tx_start at t+2.
  - Data with L>0: first ep_rd_en at t+2, first send_w_en at t+3, last send_w_en at t+2+L, tx_start at t+3+L.
  - ZLP: tx_start at t+2.
- busy is high from t+1 through the cycle of the handshake event.
- ep_done/ep_rewind are asserted the cycle after host_ack/host_timeout.

## Structure
- Shared package usb_pkg holds: PID codes (DATA0/DATA1/NAK/STALL), the tx_pid encoding, handshake codes, and the state enum.
- One sub-module: usb_toggle_bank, which implements the NUM_EP toggle register with clr/setup/flip priority.
- Byte counter width: clog2(MAX_PKT+1).

## Test plan
- IN to EP1, ep_ready=1, L=3, data A1 A2 A3, host_ack -> send queue holds A1 A2 A3; tx_pid=DATA0; ep_done[1] pulses; the next IN on EP1 yields DATA1.
- IN to EP2 with host_timeout -> ep_rewind[2] pulses; the retry uses the same DATA0 PID and resends identical bytes.
- IN to EP1 with ep_ready=0 -> tx_start at t+2 with tx_pid=NAK, no writes; IN to token_ep=9 (NUM_EP=4) -> STALL.
- setup_rx, then IN to EP0 with L=0 -> zero-length DATA1, tx_start at t+2; toggle_clr during WAIT_HS plus ack on the same cycle -> toggle ends at 0.
- Second in_token during FILL -> ignored, byte count unchanged; rst asserted during FILL -> all outputs 0 next cycle, no ep_done or ep_rewind.
